// File: rtl/rvc_compressor_pkg.sv
// rvc_compressor_pkg: RV32I/RVC encoding constants, packer state and
// compressed-result type shared by the compressor and its encoder.
`default_nettype none
package rvc_compressor_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [6:0] F7_ADD     = 7'b0000000;

   localparam logic [1:0]  CQ0       = 2'b00;
   localparam logic [1:0]  CQ1       = 2'b01;
   localparam logic [1:0]  CQ2       = 2'b10;
   localparam logic [2:0]  CF3_ADDI  = 3'b000;
   localparam logic [2:0]  CF3_LI    = 3'b010;
   localparam logic [2:0]  CF3_LW    = 3'b010;
   localparam logic [2:0]  CF3_SW    = 3'b110;
   localparam logic [3:0]  CF4_MV    = 4'b1000;
   localparam logic [3:0]  CF4_ADD   = 4'b1001;
   localparam logic [15:0] C_NOP     = 16'h0001;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_t;

   typedef struct packed {
      logic        is16;
      logic [31:0] bits;
   } comp_t;

   // Compressed register fields only reach x8..x15.
   function automatic logic is_creg(input logic [4:0] r);
      return r[4:3] == 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rvc_compressor_encode.sv
// rvc_encode: combinational RV32I -> RVC substitution; first match wins,
// non-compressible words pass through with is16 clear.
`default_nettype none
module rvc_encode
   import rvc_compressor_pkg::*;
(
   input  logic [31:0] instr,
   output comp_t       res
);

   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [11:0] w_imm_i, w_imm_s;
   logic        w_fits6, w_is_addi, w_is_add, w_is_lw, w_is_sw, w_off_i_ok, w_off_s_ok;

   assign w_opc   = instr[6:0];
   assign w_rd    = instr[11:7];
   assign w_f3    = instr[14:12];
   assign w_rs1   = instr[19:15];
   assign w_rs2   = instr[24:20];
   assign w_f7    = instr[31:25];
   assign w_imm_i = instr[31:20];
   assign w_imm_s = {instr[31:25], instr[11:7]};

   assign w_fits6    = (w_imm_i[11:5] == 7'h00) || (w_imm_i[11:5] == 7'h7F);
   assign w_is_addi  = (w_opc == OPC_OP_IMM) && (w_f3 == F3_ADD);
   assign w_is_add   = (w_opc == OPC_OP) && (w_f3 == F3_ADD) && (w_f7 == F7_ADD);
   assign w_is_lw    = (w_opc == OPC_LOAD) && (w_f3 == F3_WORD);
   assign w_is_sw    = (w_opc == OPC_STORE) && (w_f3 == F3_WORD);
   // Word offsets 0..124 in steps of 4.
   assign w_off_i_ok = (w_imm_i[11:7] == 5'd0) && (w_imm_i[1:0] == 2'd0);
   assign w_off_s_ok = (w_imm_s[11:7] == 5'd0) && (w_imm_s[1:0] == 2'd0);

   always_comb begin
      res.is16 = 1'b1;
      res.bits = 32'd0;
      if (w_is_addi && w_rd == 5'd0 && w_rs1 == 5'd0 && w_imm_i == 12'd0)
         res.bits[15:0] = C_NOP;
      else if (w_is_addi && w_rd != 5'd0 && w_rs1 == 5'd0 && w_fits6)
         res.bits[15:0] = {CF3_LI, w_imm_i[5], w_rd, w_imm_i[4:0], CQ1};
      else if (w_is_addi && w_rd != 5'd0 && w_rd == w_rs1 && w_imm_i != 12'd0 && w_fits6)
         res.bits[15:0] = {CF3_ADDI, w_imm_i[5], w_rd, w_imm_i[4:0], CQ1};
      else if (w_is_add && w_rd != 5'd0 && w_rs1 == 5'd0 && w_rs2 != 5'd0)
         res.bits[15:0] = {CF4_MV, w_rd, w_rs2, CQ2};
      else if (w_is_add && w_rd != 5'd0 && w_rd == w_rs1 && w_rs2 != 5'd0)
         res.bits[15:0] = {CF4_ADD, w_rd, w_rs2, CQ2};
      else if (w_is_lw && is_creg(w_rd) && is_creg(w_rs1) && w_off_i_ok)
         res.bits[15:0] = {CF3_LW, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6],
                           w_rd[2:0], CQ0};
      else if (w_is_sw && is_creg(w_rs2) && is_creg(w_rs1) && w_off_s_ok)
         res.bits[15:0] = {CF3_SW, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6],
                           w_rs2[2:0], CQ0};
      else begin
         res.is16 = 1'b0;
         res.bits = instr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rvc_compressor.sv
// +---------------------------------------------------------------------------+
// | rvc_compressor: RV32I->RVC compressor packing a 16/32-bit stream into     |
// | 32-bit words. Option macro: COMPRESSOR_STATS_EN (cnt_total/compressed).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none
module rvc_compressor
   import rvc_compressor_pkg::*;
#(
   parameter logic [15:0] NOP_HALF = 16'h0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        flush,
   output logic        flush_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        err
`ifdef COMPRESSOR_STATS_EN
  ,output logic [31:0] cnt_total,
   output logic [31:0] cnt_compressed
`endif
);

   pack_state_t r_state, w_state_nx;
   logic [15:0] r_pend, w_pend_nx;
   logic [31:0] w_word_nx;
   logic        r_flush, w_flush_nx, w_valid_nx, w_done_nx, w_err_nx;
   logic        w_accept, w_service;
   comp_t       w_comp;

   rvc_encode u_encode (
      .instr (in_instr),
      .res   (w_comp)
   );

   assign in_ready  = !out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   // A pending flush only proceeds in an idle cycle where the output can move.
   assign w_service = r_flush && !w_accept && in_ready;

   always_comb begin
      w_state_nx = r_state;
      w_pend_nx  = r_pend;
      w_word_nx  = out_word;
      w_valid_nx = out_valid && !out_ready;
      w_flush_nx = (r_flush && !w_service) || flush;
      w_done_nx  = 1'b0;
      w_err_nx   = w_accept && (in_instr[1:0] != 2'b11);
      if (w_accept) begin
         case (r_state)
            ST_EMPTY: begin
               if (w_comp.is16) begin
                  w_pend_nx  = w_comp.bits[15:0];
                  w_state_nx = ST_HALF;
               end else begin
                  w_word_nx  = w_comp.bits;
                  w_valid_nx = 1'b1;
               end
            end
            default: begin
               w_word_nx  = {w_comp.bits[15:0], r_pend};
               w_valid_nx = 1'b1;
               if (w_comp.is16)
                  w_state_nx = ST_EMPTY;
               else
                  w_pend_nx = w_comp.bits[31:16];
            end
         endcase
      end else if (w_service) begin
         w_done_nx = 1'b1;
         if (r_state == ST_HALF) begin
            w_word_nx  = {NOP_HALF, r_pend};
            w_valid_nx = 1'b1;
            w_state_nx = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_EMPTY;
         r_pend     <= 16'd0;
         r_flush    <= 1'b0;
         out_word   <= 32'd0;
         out_valid  <= 1'b0;
         flush_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_pend     <= w_pend_nx;
         r_flush    <= w_flush_nx;
         out_word   <= w_word_nx;
         out_valid  <= w_valid_nx;
         flush_done <= w_done_nx;
         err        <= w_err_nx;
      end
   end

`ifdef COMPRESSOR_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_total      <= 32'd0;
         cnt_compressed <= 32'd0;
      end else if (w_accept) begin
         if (cnt_total != 32'hFFFF_FFFF)
            cnt_total <= cnt_total + 32'd1;
         if (w_comp.is16 && cnt_compressed != 32'hFFFF_FFFF)
            cnt_compressed <= cnt_compressed + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvc_compressor.sv
// tb_rvc_compressor: directed vectors with hand-computed packed words.
`default_nettype none
module tb_rvc_compressor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, flush_done, out_valid, out_ready, err;
   logic [31:0] in_instr, out_word;
`ifdef COMPRESSOR_STATS_EN
   logic [31:0] cnt_total, cnt_compressed;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_total = 0;
   int exp_comp  = 0;

   always #5 clk = ~clk;

   rvc_compressor #(.NOP_HALF(16'h0001)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .flush      (flush),
      .flush_done (flush_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .err        (err)
`ifdef COMPRESSOR_STATS_EN
     ,.cnt_total      (cnt_total),
      .cnt_compressed (cnt_compressed)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Presents one instruction, waits (bounded) for in_ready, completes the accept.
   task automatic send(input logic [31:0] instr, input bit c16);
      int n = 0;
      in_valid = 1'b1;
      in_instr = instr;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      exp_total++;
      if (c16) exp_comp++;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic check_stats(input string tag);
`ifdef COMPRESSOR_STATS_EN
      check({tag, "_total"}, cnt_total, 32'(exp_total));
      check({tag, "_comp"}, cnt_compressed, 32'(exp_comp));
`endif
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
      step(); step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_word", out_word, 32'd0);
      check("rst_done", 32'(flush_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      step();

      // C.ADDI then C.LI pack into one word
      send(32'h00508093, 1'b1);
      check("s1_half_novalid", 32'(out_valid), 32'd0);
      send(32'hFFF00113, 1'b1);
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_word", out_word, 32'h517D0095);
      step();
      check("s1_drop", 32'(out_valid), 32'd0);

      // C.LW, 32-bit LUI straddles, flush pads with C.NOP
      send(32'h0044A403, 1'b1);
      send(32'h123452B7, 1'b0);
      check("s2_word", out_word, 32'h52B740C0);
      check("s2_valid", 32'(out_valid), 32'd1);
      pulse_flush();
      check("s2_early_done", 32'(flush_done), 32'd0);
      step();
      check("s2_pad_valid", 32'(out_valid), 32'd1);
      check("s2_pad_word", out_word, 32'h00011234);
      check("s2_done", 32'(flush_done), 32'd1);
      step();
      check("s2_done_clear", 32'(flush_done), 32'd0);

      // imm 32 is out of range: passes through; flush from EMPTY only pulses done
      send(32'h02008093, 1'b0);
      check("s3_word", out_word, 32'h02008093);
      pulse_flush();
      step();
      check("s3_done", 32'(flush_done), 32'd1);
      check("s3_novalid", 32'(out_valid), 32'd0);

      // Backpressure
      send(32'h00508093, 1'b1);
      out_ready = 1'b0;
      send(32'h00000013, 1'b1);
      in_valid = 1'b1;
      in_instr = 32'h02008093;
      for (int i = 0; i < 3; i++) begin
         step();
         check("s4_stall_ready", 32'(in_ready), 32'd0);
         check("s4_stall_word", out_word, 32'h00010095);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      exp_total++;
      check("s4_next_valid", 32'(out_valid), 32'd1);
      check("s4_next_word", out_word, 32'h02008093);
      step();
      check("s4_no_dup", 32'(out_valid), 32'd0);
      check_stats("s4_stats");

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'h0044A403, 1'b1);
      send(32'h123452B7, 1'b0);
      check("s5_pre_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("s5_async_valid", 32'(out_valid), 32'd0);
      check("s5_async_word", out_word, 32'd0);
      exp_total = 0;
      exp_comp  = 0;
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      pulse_flush();
      step();
      check("s5_flush_done", 32'(flush_done), 32'd1);
      check("s5_flush_noword", 32'(out_valid), 32'd0);

      // Illegal low bits: err pulse, pass-through
      send(32'h00000000, 1'b0);
      check("s6_err", 32'(err), 32'd1);
      check("s6_valid", 32'(out_valid), 32'd1);
      check("s6_word", out_word, 32'h00000000);
      step();
      check("s6_err_clear", 32'(err), 32'd0);

      // Remaining encodings and boundaries
      send(32'h00B00533, 1'b1);
      send(32'h00B50533, 1'b1);
      check("s7_mv_add", out_word, 32'h952E852E);
      send(32'h00942423, 1'b1);
      send(32'h0804A403, 1'b0);
      check("s7_sw_lw128", out_word, 32'hA403C404);
      send(32'h01F00093, 1'b1);
      check("s7_li31", out_word, 32'h40FD0804);
      send(32'hFE008093, 1'b1);
      send(32'h00000013, 1'b1);
      check("s7_addi_m32_nop", out_word, 32'h00011081);
      send(32'h00008093, 1'b0);
      check("s7_addi_zero_imm", out_word, 32'h00008093);
      check("s7_err_none", 32'(err), 32'd0);
      step();
      check_stats("s7_stats");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
